// File: rtl/mac_pot_pe_if.sv
// Port bundle of one power-of-two MAC processing element: forwarded operands,
// the vertical drain chain, status and a debug view of the FSM state.
interface mac_pot_pe_if #(
  parameter int ACT_W   = 8,
  parameter int SHIFT_W = 3,
  parameter int ACC_W   = 16
);
  localparam int WC_W = SHIFT_W + 2;

  logic [WC_W-1:0]  w_in;
  logic [WC_W-1:0]  w_out;
  logic [ACT_W-1:0] a_in;
  logic [ACT_W-1:0] a_out;
  logic             a_valid_in;
  logic             a_last_in;
  logic             a_valid_out;
  logic             a_last_out;
  logic             drain;
  logic [ACC_W-1:0] psum_in;
  logic             psum_vld_in;
  logic             psum_sat_in;
  logic [ACC_W-1:0] psum_out;
  logic             psum_vld_out;
  logic             psum_sat_out;
  logic             perr_out;
  logic [1:0]       dbg_state;

  // Handshake: a term is consumed on every rising edge with a_valid_in=1 and drain=0
  // (no ready, the PE always accepts); psum_vld_out=1 marks a finished result being held.
  modport slave (
    input  w_in, a_in, a_valid_in, a_last_in, drain, psum_in, psum_vld_in, psum_sat_in,
    output w_out, a_out, a_valid_out, a_last_out, psum_out, psum_vld_out, psum_sat_out,
    output perr_out, dbg_state
  );

  modport master (
    output w_in, a_in, a_valid_in, a_last_in, drain, psum_in, psum_vld_in, psum_sat_in,
    input  w_out, a_out, a_valid_out, a_last_out, psum_out, psum_vld_out, psum_sat_out,
    input  perr_out, dbg_state
  );
endinterface

// File: rtl/mac_pot_pe.sv
// Systolic PE that accumulates activation * (+/-2^shift) terms into a signed,
// optionally saturating dot product and hands results down a drain chain.
module mac_pot_pe #(
  parameter int ACT_W    = 8,
  parameter int SHIFT_W  = 3,
  parameter int ACC_W    = 16,
  parameter int SATURATE = 1
) (
  input  logic        clk,
  input  logic        reset,
  mac_pot_pe_if.slave pe
);
  localparam int WC_W = SHIFT_W + 2;
  localparam int PW   = ACT_W + (1 << SHIFT_W);
  localparam int SW   = ((ACC_W > PW) ? ACC_W : PW) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [WC_W-1:0]  w_q;
  logic [ACT_W-1:0] a_q;
  logic             a_valid_q;
  logic             a_last_q;
  logic [ACC_W-1:0] acc_q;
  logic             sat_q;
  logic             vld_q;
  logic             perr_q;

  logic             zero_w;
  logic             sign_w;
  logic [SHIFT_W-1:0] shamt;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    mag;
  logic [PW-1:0]    prod;
  logic [SW-1:0]    base;
  logic [SW-1:0]    sum;
  logic             ovf;
  logic             clamp;
  logic [ACC_W-1:0] acc_d;
  logic             sat_d;

  assign zero_w = pe.w_in[WC_W-1];
  assign sign_w = pe.w_in[SHIFT_W];
  assign shamt  = pe.w_in[SHIFT_W-1:0];

  // Sum is formed one bit wider than either operand so overflow is always detectable.
  always_comb begin
    a_ext = {{(PW-ACT_W){pe.a_in[ACT_W-1]}}, pe.a_in};
    mag   = a_ext << shamt;
    prod  = '0;
    if (!zero_w) prod = sign_w ? -mag : mag;
    base  = (state_q == ACC) ? {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q} : '0;
    sum   = base + {{(SW-PW){prod[PW-1]}}, prod};
    ovf   = (sum[SW-1:ACC_W-1] != {(SW-ACC_W+1){sum[SW-1]}});
    clamp = (SATURATE != 0) && ovf;
    acc_d = sum[ACC_W-1:0];
    if (clamp) acc_d = sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    sat_d = ((state_q == ACC) && sat_q) || clamp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      w_q       <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      a_last_q  <= 1'b0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      w_q       <= pe.w_in;
      a_q       <= pe.a_in;
      a_valid_q <= pe.a_valid_in;
      a_last_q  <= pe.a_last_in;
      if (pe.drain) begin
        // Drain overrides accumulation; a term or a partial sum caught here is a protocol error.
        acc_q   <= pe.psum_in;
        sat_q   <= pe.psum_sat_in;
        state_q <= pe.psum_vld_in ? DONE : IDLE;
        vld_q   <= pe.psum_vld_in;
        if (pe.a_valid_in || state_q == ACC) perr_q <= 1'b1;
      end else if (pe.a_valid_in) begin
        acc_q   <= acc_d;
        sat_q   <= sat_d;
        state_q <= pe.a_last_in ? DONE : ACC;
        vld_q   <= pe.a_last_in;
      end
    end
  end

  assign pe.w_out        = w_q;
  assign pe.a_out        = a_q;
  assign pe.a_valid_out  = a_valid_q;
  assign pe.a_last_out   = a_last_q;
  assign pe.psum_out     = acc_q;
  assign pe.psum_vld_out = vld_q;
  assign pe.psum_sat_out = sat_q;
  assign pe.perr_out     = perr_q;
  assign pe.dbg_state    = state_q;
endmodule

// File: tb/tb_mac_pot_pe.sv
// Bench for mac_pot_pe: a saturating and a wrapping PE share one stimulus stream
// against an arithmetic reference model; a 4-PE column exercises the drain chain.
module tb_mac_pot_pe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // stimulus shared by the saturating (index 0) and wrapping (index 1) PEs
  logic [7:0]  a_in;
  logic [4:0]  w_in;
  logic        a_valid, a_last, drain;
  logic [15:0] psum_in;
  logic        psum_vld_in, psum_sat_in;

  logic [15:0] p_psum[2];
  logic        p_vld[2], p_sat[2], p_perr[2], p_av[2], p_al[2];
  logic [7:0]  p_aout[2];
  logic [4:0]  p_wout[2];

  mac_pot_pe_if #(.ACT_W(8), .SHIFT_W(3), .ACC_W(16)) pair_if [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_pair
    assign pair_if[g].w_in        = w_in;
    assign pair_if[g].a_in        = a_in;
    assign pair_if[g].a_valid_in  = a_valid;
    assign pair_if[g].a_last_in   = a_last;
    assign pair_if[g].drain       = drain;
    assign pair_if[g].psum_in     = psum_in;
    assign pair_if[g].psum_vld_in = psum_vld_in;
    assign pair_if[g].psum_sat_in = psum_sat_in;
    assign p_psum[g] = pair_if[g].psum_out;
    assign p_vld[g]  = pair_if[g].psum_vld_out;
    assign p_sat[g]  = pair_if[g].psum_sat_out;
    assign p_perr[g] = pair_if[g].perr_out;
    assign p_aout[g] = pair_if[g].a_out;
    assign p_wout[g] = pair_if[g].w_out;
    assign p_av[g]   = pair_if[g].a_valid_out;
    assign p_al[g]   = pair_if[g].a_last_out;
    mac_pot_pe #(.ACT_W(8), .SHIFT_W(3), .ACC_W(16), .SATURATE(g == 0 ? 1 : 0)) u_pe (
      .clk   (clk),
      .reset (reset),
      .pe    (pair_if[g])
    );
  end

  // 4-PE column
  logic [7:0]  c_a[4];
  logic [4:0]  c_w;
  logic        c_valid, c_last, c_drain;
  logic [15:0] c_psum[4];
  logic        c_vld[4], c_perr[4];

  mac_pot_pe_if #(.ACT_W(8), .SHIFT_W(3), .ACC_W(16)) col_if [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_col
    assign col_if[g].w_in       = c_w;
    assign col_if[g].a_in       = c_a[g];
    assign col_if[g].a_valid_in = c_valid;
    assign col_if[g].a_last_in  = c_last;
    assign col_if[g].drain      = c_drain;
    if (g == 0) begin : g_top
      assign col_if[g].psum_in     = 16'd0;
      assign col_if[g].psum_vld_in = 1'b0;
      assign col_if[g].psum_sat_in = 1'b0;
    end else begin : g_chain
      assign col_if[g].psum_in     = col_if[g-1].psum_out;
      assign col_if[g].psum_vld_in = col_if[g-1].psum_vld_out;
      assign col_if[g].psum_sat_in = col_if[g-1].psum_sat_out;
    end
    assign c_psum[g] = col_if[g].psum_out;
    assign c_vld[g]  = col_if[g].psum_vld_out;
    assign c_perr[g] = col_if[g].perr_out;
    mac_pot_pe #(.ACT_W(8), .SHIFT_W(3), .ACC_W(16), .SATURATE(1)) u_pe (
      .clk   (clk),
      .reset (reset),
      .pe    (col_if[g])
    );
  end

  // scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] col_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: mode 0 idle, 1 accumulating, 2 result held
  int         m_acc[2];
  bit         m_sat[2], m_perr[2], m_new[2];
  int         m_mode[2];
  logic [7:0] m_a;
  logic [4:0] m_w;
  bit         m_av, m_al;

  function automatic int term(input logic [7:0] a, input logic [4:0] w);
    int mag;
    mag = int'($signed(a)) * (1 << w[2:0]);
    if (w[4]) return 0;
    return w[3] ? -mag : mag;
  endfunction

  function automatic int wrap16(input int v);
    int r;
    r = v % 65536;
    if (r > 32767) r -= 65536;
    if (r < -32768) r += 65536;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_sat[k] = 0; m_perr[k] = 0; m_mode[k] = 0; m_new[k] = 0;
    end
    m_a = '0; m_w = '0; m_av = 0; m_al = 0;
    exp_q.delete();
  endtask

  task automatic model_tick();
    int  s;
    bit  c;
    for (int k = 0; k < 2; k++) begin
      m_new[k] = 0;
      if (drain) begin
        if (a_valid || m_mode[k] == 1) m_perr[k] = 1;
        m_acc[k]  = int'($signed(psum_in));
        m_sat[k]  = psum_sat_in;
        m_mode[k] = psum_vld_in ? 2 : 0;
      end else if (a_valid) begin
        s = (m_mode[k] == 1 ? m_acc[k] : 0) + term(a_in, w_in);
        c = 0;
        if (k == 0) begin
          if (s > 32767) begin s = 32767; c = 1; end
          else if (s < -32768) begin s = -32768; c = 1; end
        end else begin
          s = wrap16(s);
        end
        m_sat[k]  = (m_mode[k] == 1 ? m_sat[k] : 0) | c;
        m_acc[k]  = s;
        m_mode[k] = a_last ? 2 : 1;
        if (a_last) begin
          m_new[k] = 1;
          exp_q.push_back(16'(s));
        end
      end
    end
    m_a = a_in; m_w = w_in; m_av = a_valid; m_al = a_last;
  endtask

  task automatic check_pair();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("psum[%0d]", k), 32'(p_psum[k]), m_acc[k] & 32'hFFFF);
      check($sformatf("vld[%0d]", k), 32'(p_vld[k]), 32'(m_mode[k] == 2));
      check($sformatf("sat[%0d]", k), 32'(p_sat[k]), 32'(m_sat[k]));
      check($sformatf("perr[%0d]", k), 32'(p_perr[k]), 32'(m_perr[k]));
      check($sformatf("a_out[%0d]", k), 32'(p_aout[k]), 32'(m_a));
      check($sformatf("w_out[%0d]", k), 32'(p_wout[k]), 32'(m_w));
      check($sformatf("av_out[%0d]", k), 32'(p_av[k]), 32'(m_av));
      check($sformatf("al_out[%0d]", k), 32'(p_al[k]), 32'(m_al));
    end
    for (int k = 0; k < 2; k++) begin
      if (m_new[k]) begin
        if (exp_q.size() == 0) check("result_q_empty", 32'd1, 32'd0);
        else check($sformatf("result[%0d]", k), 32'(p_psum[k]), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check_pair();
  endtask

  task automatic drive(input logic [7:0] a, input logic [4:0] w, input bit v, input bit l, input bit d);
    a_in = a; w_in = w; a_valid = v; a_last = l; drain = d;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_pair();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(8'd0, 5'd0, 0, 0, 0);
    psum_in = 16'd0; psum_vld_in = 1'b0; psum_sat_in = 1'b0;
    for (int g = 0; g < 4; g++) c_a[g] = 8'd0;
    c_w = 5'd0; c_valid = 1'b0; c_last = 1'b0; c_drain = 1'b0;
    model_reset();
    #2;
    check_pair();
    check("col_reset_psum", 32'(c_psum[3]), 32'd0);
    check("col_reset_vld", 32'(c_vld[3]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // dot product 5*8 + -(-3*4)
    drive(8'd5, 5'b00011, 1, 0, 0); step();
    check("t1_partial", 32'(p_psum[0]), 32'd40);
    check("t1_partial_vld", 32'(p_vld[0]), 32'd0);
    drive(8'hFD, 5'b01010, 1, 1, 0); step();
    check("t1_result", 32'(p_psum[0]), 32'd52);
    check("t1_vld", 32'(p_vld[0]), 32'd1);
    check("t1_sat", 32'(p_sat[0]), 32'd0);
    drive(8'd0, 5'd0, 0, 0, 0); step();

    // 3 x 127*128 saturates on one PE and wraps on the other
    drive(8'd127, 5'b00111, 1, 0, 0); step();
    check("t2_s1", 32'(p_psum[0]), 32'd16256);
    step();
    check("t2_s2", 32'(p_psum[0]), 32'd32512);
    drive(8'd127, 5'b00111, 1, 1, 0); step();
    check("t2_sat_val", 32'(p_psum[0]), 32'h7FFF);
    check("t2_sat_flag", 32'(p_sat[0]), 32'd1);
    check("t2_wrap_val", 32'(p_psum[1]), 32'hBE80);
    check("t2_wrap_flag", 32'(p_sat[1]), 32'd0);
    drive(8'd0, 5'd0, 0, 0, 0); step();

    // zero-flagged weight contributes nothing
    drive(8'h80, 5'b11111, 1, 0, 0); step();
    check("t3_a_echo", 32'(p_aout[0]), 32'h80);
    check("t3_w_echo", 32'(p_wout[0]), 32'h1F);
    drive(8'd2, 5'b01000, 1, 1, 0); step();
    check("t3_result", 32'(p_psum[0]), 32'hFFFE);
    check("t3_result_w", 32'(p_psum[1]), 32'hFFFE);
    drive(8'd0, 5'd0, 0, 0, 0); step();

    // randomized traffic including occasional drains
    for (int i = 0; i < 400; i++) begin
      a_in        = 8'($urandom_range(0, 255));
      w_in        = {($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15))};
      a_valid     = ($urandom_range(0, 9) < 7);
      a_last      = ($urandom_range(0, 3) == 0);
      drain       = ($urandom_range(0, 19) == 0);
      psum_in     = 16'($urandom);
      psum_vld_in = 1'($urandom_range(0, 1));
      psum_sat_in = 1'($urandom_range(0, 1));
      step();
    end
    drive(8'd0, 5'd0, 0, 0, 0);
    psum_in = 16'd0; psum_vld_in = 1'b0; psum_sat_in = 1'b0;
    pulse_reset();

    // drain collides with a term while accumulating
    drive(8'd100, 5'b00000, 1, 0, 0); step();
    check("t5_acc", 32'(p_psum[0]), 32'd100);
    check("t5_perr_before", 32'(p_perr[0]), 32'd0);
    drive(8'd7, 5'b00000, 1, 0, 1); step();
    check("t5_perr", 32'(p_perr[0]), 32'd1);
    check("t5_not_added", 32'(p_psum[0]), 32'd0);
    check("t5_a_fwd", 32'(p_aout[0]), 32'd7);
    drive(8'd3, 5'b00000, 1, 1, 0); step();
    check("t5_restart", 32'(p_psum[0]), 32'd3);
    check("t5_perr_sticky", 32'(p_perr[0]), 32'd1);
    drive(8'd0, 5'd0, 0, 0, 0);
    pulse_reset();

    // asynchronous reset in the middle of a dot product
    drive(8'd75, 5'b00010, 1, 0, 0); step();
    check("t6_acc", 32'(p_psum[0]), 32'd300);
    drive(8'd0, 5'd0, 0, 0, 0);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_async_psum", 32'(p_psum[0]), 32'd0);
    check("t6_async_aout", 32'(p_aout[0]), 32'd0);
    check_pair();
    @(negedge clk);
    reset = 1'b0;
    drive(8'd1, 5'b00000, 1, 1, 0); step();
    check("t6_after", 32'(p_psum[0]), 32'd1);
    drive(8'd0, 5'd0, 0, 0, 0);

    // column: load 10,20,30,40 then drain them out of the bottom PE
    for (int g = 0; g < 4; g++) c_a[g] = 8'(10 * (g + 1));
    c_valid = 1'b1; c_last = 1'b1;
    step();
    c_valid = 1'b0; c_last = 1'b0;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("col_load[%0d]", g), 32'(c_psum[g]), 32'(10 * (g + 1)));
      check($sformatf("col_load_vld[%0d]", g), 32'(c_vld[g]), 32'd1);
    end
    for (int g = 3; g >= 0; g--) col_q.push_back(16'(10 * (g + 1)));
    c_drain = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("col_bottom[%0d]", i), 32'(c_psum[3]), 32'(col_q.pop_front()));
      check($sformatf("col_bottom_vld[%0d]", i), 32'(c_vld[3]), 32'd1);
      step();
    end
    c_drain = 1'b0;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("col_end_vld[%0d]", g), 32'(c_vld[g]), 32'd0);
      check($sformatf("col_end_psum[%0d]", g), 32'(c_psum[g]), 32'd0);
      check($sformatf("col_end_perr[%0d]", g), 32'(c_perr[g]), 32'd0);
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
